// File: rtl/multitone_synth_pkg.sv
// Shared sizing, per-tone configuration record, frame states and the
// sine-table generator used by the multi-tone DDS.
package multitone_synth_pkg;

    localparam int SOURCE_WIDTH = 14;
    localparam int NUM_TONES    = 4;
    localparam int PHASE_WIDTH  = 32;
    localparam int LUT_DEPTH    = 10;
    localparam int AMP_WIDTH    = 14;

    localparam int TONE_W   = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;
    localparam int LUT_SIZE = 1 << LUT_DEPTH;
    localparam int SUM_W    = SOURCE_WIDTH + $clog2(NUM_TONES) + 2;
    localparam int PROD_W   = 16 + AMP_WIDTH + 1;
    localparam int Q15_ONE  = 32767;

    typedef struct packed {
        logic [PHASE_WIDTH-1:0] ftw;
        logic [PHASE_WIDTH-1:0] pofs;
        logic [AMP_WIDTH-1:0]   amp;
    } tone_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } frame_state_e;

    // Table entry k of a full sine wave in Q1.15, rounded to nearest.
    function automatic logic signed [15:0] sine_q15(input int k);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_SIZE);
        return 16'(int'(real'(Q15_ONE) * $sin(ang)));
    endfunction

endpackage

// File: rtl/multitone_synth_if.sv
// Sample request / tone configuration / sample output bundle of the DDS.
interface multitone_synth_if;
    import multitone_synth_pkg::*;

    logic                           sample_en;
    logic                           cfg_we;
    logic [TONE_W-1:0]              cfg_tone;
    logic [PHASE_WIDTH-1:0]         cfg_ftw;
    logic [PHASE_WIDTH-1:0]         cfg_pofs;
    logic [AMP_WIDTH-1:0]           cfg_amp;
    logic                           cfg_sync;
    logic                           overrun_clr;
    logic signed [SOURCE_WIDTH-1:0] source;
    logic                           source_valid;
    logic                           busy;
    logic                           overrun;

    modport master (
        output sample_en, cfg_we, cfg_tone, cfg_ftw, cfg_pofs, cfg_amp, cfg_sync, overrun_clr,
        input  source, source_valid, busy, overrun
    );

    modport slave (
        input  sample_en, cfg_we, cfg_tone, cfg_ftw, cfg_pofs, cfg_amp, cfg_sync, overrun_clr,
        output source, source_valid, busy, overrun
    );

endinterface

// File: rtl/multitone_synth_sine_rom.sv
// Full-wave Q1.15 sine table with a registered read port (one cycle latency).
module multitone_synth_sine_rom
    import multitone_synth_pkg::*;
(
    input  logic                 clk,
    input  logic [LUT_DEPTH-1:0] addr_i,
    output logic signed [15:0]   data_o
);

    logic signed [15:0] rom_w [LUT_SIZE];
    logic signed [15:0] data_q;

    for (genvar k = 0; k < LUT_SIZE; k++) begin : g_rom
        assign rom_w[k] = sine_q15(k);
    end

    // Registered table read.
    always_ff @(posedge clk) begin
        data_q <= rom_w[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/multitone_synth.sv
// Time-multiplexed multi-tone DDS: one frame per accepted sample request,
// tones issued back to back through phase add -> sine ROM -> scale -> accumulate,
// then the saturated sum is presented as one signed sample.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for sample_en; accept copies live cfg to shadow cfg
// ST_ISSUE | one tone per cycle: ROM address out, accumulator advanced
// ST_DRAIN | three cycles letting the last tone reach the sum; then output
module multitone_synth
    import multitone_synth_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    multitone_synth_if.slave bus
);

    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (SOURCE_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(2 ** (SOURCE_WIDTH - 1)));

    frame_state_e                   state_q, state_d;
    logic [TONE_W-1:0]              tone_q, tone_d;
    logic [1:0]                     drain_q, drain_d;
    logic                           accept, issue, done;

    tone_cfg_t                      live_q   [NUM_TONES];
    tone_cfg_t                      live_d   [NUM_TONES];
    tone_cfg_t                      shadow_q [NUM_TONES];
    logic [PHASE_WIDTH-1:0]         acc_q    [NUM_TONES];
    logic                           sync_q;

    logic [LUT_DEPTH-1:0]           addr_w;
    logic signed [15:0]             sine_w;
    logic [AMP_WIDTH-1:0]           amp_q;
    logic                           mul_v_q, add_v_q;
    logic signed [PROD_W-1:0]       prod_w;
    logic signed [15:0]             term_q;
    logic signed [SUM_W-1:0]        sum_q;
    logic signed [SOURCE_WIDTH-1:0] source_q;
    logic                           valid_q, overrun_q;

    function automatic logic signed [SOURCE_WIDTH-1:0] saturate(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI) return SOURCE_WIDTH'(SAT_HI);
        if (v < SAT_LO) return SOURCE_WIDTH'(SAT_LO);
        return SOURCE_WIDTH'(v);
    endfunction

    // Frame sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tone_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            drain_q <= drain_d;
        end
    end

    // Frame sequencer next state and per-cycle strobes.
    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        drain_d = drain_q;
        accept  = 1'b0;
        issue   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.sample_en) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                    tone_d  = '0;
                end
            end
            ST_ISSUE: begin
                issue = 1'b1;
                if (tone_q == TONE_W'(NUM_TONES - 1)) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'd2;
                end else begin
                    tone_d = tone_q + TONE_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Live config with this cycle's write folded in, so an accept sees it.
    always_comb begin
        live_d = live_q;
        for (int t = 0; t < NUM_TONES; t++) begin
            if (bus.cfg_we && bus.cfg_tone == TONE_W'(t)) begin
                live_d[t] = '{ftw: bus.cfg_ftw, pofs: bus.cfg_pofs, amp: bus.cfg_amp};
            end
        end
    end

    // Live registers track writes; shadow registers freeze them per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_TONES; t++) begin
                live_q[t]   <= '0;
                shadow_q[t] <= '0;
            end
        end else begin
            live_q <= live_d;
            if (accept) shadow_q <= live_d;
        end
    end

    // Phase accumulators advance as each tone is issued; a pending sync zeroes them at accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_TONES; t++) acc_q[t] <= '0;
            sync_q <= 1'b0;
        end else if (accept) begin
            sync_q <= 1'b0;
            if (sync_q || bus.cfg_sync) begin
                for (int t = 0; t < NUM_TONES; t++) acc_q[t] <= '0;
            end
        end else begin
            if (bus.cfg_sync) sync_q <= 1'b1;
            if (issue) acc_q[tone_q] <= acc_q[tone_q] + shadow_q[tone_q].ftw;
        end
    end

    assign addr_w = LUT_DEPTH'((acc_q[tone_q] + shadow_q[tone_q].pofs) >> (PHASE_WIDTH - LUT_DEPTH));

    multitone_synth_sine_rom u_rom (
        .clk    (clk),
        .addr_i (addr_w),
        .data_o (sine_w)
    );

    assign prod_w = PROD_W'(sine_w) * PROD_W'($signed({1'b0, amp_q}));

    // Scale and accumulate pipeline, aligned to the ROM output.
    always_ff @(posedge clk) begin
        if (reset) begin
            amp_q   <= '0;
            mul_v_q <= 1'b0;
            add_v_q <= 1'b0;
            term_q  <= '0;
            sum_q   <= '0;
        end else begin
            amp_q   <= shadow_q[tone_q].amp;
            mul_v_q <= issue;
            add_v_q <= mul_v_q;
            term_q  <= 16'(prod_w >>> 15);
            if (accept) begin
                sum_q <= '0;
            end else if (add_v_q) begin
                sum_q <= sum_q + SUM_W'(term_q);
            end
        end
    end

    // Output sample, valid pulse and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            source_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= done;
            if (done) source_q <= saturate(sum_q);
            if (bus.sample_en && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.source       = source_q;
    assign bus.source_valid = valid_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_multitone_synth.sv
// Self-checking bench for multitone_synth with a frame-level reference model.
module tb_multitone_synth;
    import multitone_synth_pkg::*;

    logic clk = 1'b0;
    logic reset;

    multitone_synth_if bus();

    multitone_synth dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_ftw  [NUM_TONES];
    logic [31:0] m_pofs [NUM_TONES];
    logic [31:0] m_acc  [NUM_TONES];
    int          m_amp  [NUM_TONES];
    bit          m_sync;

    function automatic int sine_ref(input int k);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 1024.0);
        if (r >= 0.0) return int'($floor(r + 0.5));
        return -int'($floor(-r + 0.5));
    endfunction

    // Expected sample of the next frame; advances the model's phases.
    function automatic int model_sample();
        longint      sum;
        logic [31:0] p;
        sum = 0;
        if (m_sync) begin
            for (int i = 0; i < NUM_TONES; i++) m_acc[i] = 32'd0;
            m_sync = 1'b0;
        end
        for (int i = 0; i < NUM_TONES; i++) begin
            p = m_acc[i] + m_pofs[i];
            sum += (longint'(sine_ref(int'(p[31:22]))) * longint'(m_amp[i])) >>> 15;
            m_acc[i] = m_acc[i] + m_ftw[i];
        end
        if (sum > 8191) return 8191;
        if (sum < -8192) return -8192;
        return int'(sum);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_TONES; i++) begin
            m_ftw[i] = 0; m_pofs[i] = 0; m_acc[i] = 0; m_amp[i] = 0;
        end
        m_sync = 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int t, input logic [31:0] ftw, input logic [31:0] pofs, input int amp);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_tone = TONE_W'(t);
        bus.cfg_ftw = ftw; bus.cfg_pofs = pofs; bus.cfg_amp = AMP_WIDTH'(amp);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        m_ftw[t] = ftw; m_pofs[t] = pofs; m_amp[t] = amp;
    endtask

    task automatic cfg_sync_pulse();
        @(negedge clk); bus.cfg_sync = 1'b1;
        @(negedge clk); bus.cfg_sync = 1'b0;
        m_sync = 1'b1;
    endtask

    // One frame; optionally rewrites tone mid_t's ftw during cycle 2 of the frame.
    task automatic run_frame(input int mid_t, input logic [31:0] mid_ftw, output int got);
        int exp, cyc;
        exp = model_sample();
        @(negedge clk); bus.sample_en = 1'b1;
        @(negedge clk); bus.sample_en = 1'b0; cyc = 1;
        while (bus.source_valid !== 1'b1 && cyc < 40) begin
            if (cyc == 2 && mid_t >= 0) begin
                bus.cfg_we = 1'b1; bus.cfg_tone = TONE_W'(mid_t); bus.cfg_ftw = mid_ftw;
                bus.cfg_pofs = m_pofs[mid_t]; bus.cfg_amp = AMP_WIDTH'(m_amp[mid_t]);
            end
            @(negedge clk); bus.cfg_we = 1'b0; cyc++;
        end
        if (mid_t >= 0) m_ftw[mid_t] = mid_ftw;
        got = int'(bus.source);
        n_total++;
        if (cyc !== 8) $display("FAIL frame_latency: got %0d cycles, expected 8", cyc);
        else n_pass++;
        n_total++;
        if (got !== exp) $display("FAIL frame_sample: got %0d, expected %0d", got, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (bus.source !== 14'sd0) $display("FAIL reset_source: got %0d, expected 0", bus.source);
        else n_pass++;
        n_total++;
        if (bus.source_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", bus.source_valid);
        else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", bus.busy);
        else n_pass++;
        n_total++;
        if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b, expected 0", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_single_tone();
        int got;
        int exp_seq [4] = '{0, 4095, 0, -4096};
        do_reset();
        cfg_write(0, 32'h4000_0000, 32'd0, 4096);
        for (int f = 0; f < 4; f++) begin
            run_frame(-1, 32'd0, got);
            n_total++;
            if (got !== exp_seq[f]) $display("FAIL single_tone[%0d]: got %0d, expected %0d", f, got, exp_seq[f]);
            else n_pass++;
        end
    endtask

    task automatic test_all_tones_sat();
        int got;
        int exp_seq [4] = '{8191, 0, -8192, 0};
        do_reset();
        for (int t = 0; t < NUM_TONES; t++) cfg_write(t, 32'h4000_0000, 32'h4000_0000, 16383);
        for (int f = 0; f < 4; f++) begin
            run_frame(-1, 32'd0, got);
            n_total++;
            if (got !== exp_seq[f]) $display("FAIL all_tones_sat[%0d]: got %0d, expected %0d", f, got, exp_seq[f]);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        int exp;
        do_reset();
        cfg_write(1, 32'h1234_5678, 32'h2000_0000, 9000);
        exp = model_sample();
        @(negedge clk); bus.sample_en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); bus.sample_en = 1'b0;
            n_total++;
            if (bus.busy !== (c <= 7)) $display("FAIL latency_busy[c%0d]: got %b, expected %b", c, bus.busy, c <= 7);
            else n_pass++;
            n_total++;
            if (bus.source_valid !== (c == 8)) $display("FAIL latency_valid[c%0d]: got %b, expected %b", c, bus.source_valid, c == 8);
            else n_pass++;
            if (c == 8) begin
                n_total++;
                if (int'(bus.source) !== exp) $display("FAIL latency_sample: got %0d, expected %0d", bus.source, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back_overrun();
        int nvalid, badpos;
        do_reset();
        nvalid = 0; badpos = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.source_valid === 1'b1) begin
                nvalid++;
                if (c % 8 != 0 || c == 0) badpos++;
            end
            bus.sample_en = (c % 4 == 0) && (c < 32);
        end
        n_total++;
        if (nvalid !== 4) $display("FAIL b2b_valid_count: got %0d, expected 4", nvalid);
        else n_pass++;
        n_total++;
        if (badpos !== 0) $display("FAIL b2b_valid_spacing: got %0d misplaced pulses, expected 0", badpos);
        else n_pass++;
        n_total++;
        if (bus.overrun !== 1'b1) $display("FAIL overrun_set: got %b, expected 1", bus.overrun);
        else n_pass++;
        @(negedge clk); bus.sample_en = 1'b1;
        @(negedge clk); bus.overrun_clr = 1'b1;
        @(negedge clk); bus.sample_en = 1'b0; bus.overrun_clr = 1'b0;
        n_total++;
        if (bus.overrun !== 1'b1) $display("FAIL overrun_clr_loses: got %b, expected 1", bus.overrun);
        else n_pass++;
        repeat (8) @(negedge clk);
        bus.overrun_clr = 1'b1;
        @(negedge clk); bus.overrun_clr = 1'b0;
        n_total++;
        if (bus.overrun !== 1'b0) $display("FAIL overrun_clear: got %b, expected 0", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_cfg_midframe();
        int got;
        int exp_seq [3] = '{0, 4095, 2896};
        do_reset();
        cfg_write(0, 32'h4000_0000, 32'd0, 4096);
        for (int f = 0; f < 3; f++) begin
            if (f == 0) run_frame(0, 32'h2000_0000, got);
            else run_frame(-1, 32'd0, got);
            n_total++;
            if (got !== exp_seq[f]) $display("FAIL cfg_midframe[%0d]: got %0d, expected %0d", f, got, exp_seq[f]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort_sync();
        int got, pulses;
        do_reset();
        cfg_write(0, 32'h1000_0000, 32'h4000_0000, 4096);
        @(negedge clk); bus.sample_en = 1'b1;
        @(negedge clk); bus.sample_en = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.source_valid === 1'b1) pulses++;
        end
        n_total++;
        if (pulses !== 0) $display("FAIL abort_no_valid: got %0d pulses, expected 0", pulses);
        else n_pass++;
        n_total++;
        if (bus.source !== 14'sd0) $display("FAIL abort_source: got %0d, expected 0", bus.source);
        else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b, expected 0", bus.busy);
        else n_pass++;
        cfg_write(0, 32'h1000_0000, 32'h4000_0000, 4096);
        run_frame(-1, 32'd0, got);
        run_frame(-1, 32'd0, got);
        cfg_sync_pulse();
        run_frame(-1, 32'd0, got);
        n_total++;
        if (got !== 4095) $display("FAIL sync_phase: got %0d, expected 4095", got);
        else n_pass++;
    endtask

    task automatic test_random();
        int got, nw, mt;
        do_reset();
        for (int r = 0; r < 12; r++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                cfg_write($urandom_range(0, NUM_TONES - 1), $urandom, $urandom, $urandom_range(0, 16383));
            end
            if ($urandom_range(0, 3) == 0) cfg_sync_pulse();
            mt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NUM_TONES - 1) : -1;
            run_frame(mt, $urandom, got);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.sample_en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_tone = '0;
        bus.cfg_ftw = '0; bus.cfg_pofs = '0; bus.cfg_amp = '0;
        bus.cfg_sync = 1'b0; bus.overrun_clr = 1'b0;
        model_reset();
        test_reset();
        test_single_tone();
        test_all_tones_sat();
        test_latency();
        test_back_to_back_overrun();
        test_cfg_midframe();
        test_reset_abort_sync();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
